alu_driver: RTL and testbench

Sequential initiator for the 32-bit combinational ALU. Accepts operation commands on a valid/ready stream, drives the ALU's operand/opcode ports from registers, captures Result and flags, optionally iterates by feeding Result back as the next A operand, and returns one response per command on a valid/ready stream. Sits between the control path and an externally instantiated ALU.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_driver.sv | 183 ++++++++++++++++++
 tb/tb_alu_driver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: widths, ALUop codes, FSM encoding
// and opcode classification helpers.
package alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ITER_W     = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // True for the five opcodes the ALU implements.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True where the ALU defines Overflow and CarryOut.
  function automatic logic is_arith_op(input logic [2:0] op);
    logic arith;
    case (op)
      OP_ADD, OP_SUB: arith = 1'b1;
      default:        arith = 1'b0;
    endcase
    return arith;
  endfunction

endpackage

// File: rtl/alu_driver.sv
// Sequential initiator for the external 32-bit combinational ALU. Takes one
// command at a time, drives the ALU from registers for N = iter+1 cycles,
// feeding Result back into A, then holds a response until it is consumed.
import alu_pkg::*;

module alu_driver #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int ITER_W     = alu_pkg::ITER_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [ITER_W-1:0]     cmd_iter,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [2:0]              op_r;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [ITER_W-1:0]       cnt_r;
  logic                    ovf_r;
  logic                    carry_r;
  logic                    zero_r;
  logic                    err_r;
  logic                    accept_s;
  logic                    cmd_legal_s;
  logic                    arith_s;

  assign accept_s    = (state_r == ST_IDLE) && cmd_valid;
  assign cmd_legal_s = is_legal_op(cmd_op);
  assign arith_s     = is_arith_op(op_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. Illegal commands also pass through one EXEC cycle (with
  // the ALU left idle) so response latency is the same as a single-pass op.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == {ITER_W{1'b0}}) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Command capture, iteration accumulator and sticky/last-value flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= 3'b000;
      acc_r   <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {ITER_W{1'b0}};
      ovf_r   <= 1'b0;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= cmd_op;
            b_r     <= cmd_b;
            ovf_r   <= 1'b0;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            if (cmd_legal_s) begin
              acc_r <= cmd_a;
              cnt_r <= cmd_iter;
              err_r <= 1'b0;
            end else begin
              acc_r <= {DATA_WIDTH{1'b0}};
              cnt_r <= {ITER_W{1'b0}};
              err_r <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (!err_r) begin
            acc_r   <= alu_Result;
            ovf_r   <= ovf_r | (arith_s & alu_Overflow);
            carry_r <= arith_s & alu_CarryOut;
            zero_r  <= alu_Zero;
          end
          if (cnt_r != {ITER_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(ITER_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          op_r <= op_r;
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  // Output decode: ALU ports only live in EXEC for legal ops, response
  // fields only visible in RESP; everything else idles at zero.
  always_comb begin
    cmd_ready    = 1'b0;
    alu_A        = {DATA_WIDTH{1'b0}};
    alu_B        = {DATA_WIDTH{1'b0}};
    alu_ALUop    = 3'b000;
    rsp_valid    = 1'b0;
    rsp_result   = {DATA_WIDTH{1'b0}};
    rsp_overflow = 1'b0;
    rsp_carry    = 1'b0;
    rsp_zero     = 1'b0;
    rsp_err      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = ~rst;
      end
      ST_EXEC: begin
        if (!err_r) begin
          alu_A     = acc_r;
          alu_B     = b_r;
          alu_ALUop = op_r;
        end else begin
          alu_ALUop = 3'b000;
        end
      end
      ST_RESP: begin
        rsp_valid    = 1'b1;
        rsp_result   = acc_r;
        rsp_overflow = ovf_r;
        rsp_carry    = carry_r;
        rsp_zero     = zero_r;
        rsp_err      = err_r;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: behavioural ALU stand-in, directed plus random
// commands compared against an arithmetic reference model.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_iter;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_Overflow;
  logic        alu_CarryOut;
  logic        alu_Zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_trace [0:15];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_iter(cmd_iter),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; flags the real ALU leaves undefined are driven to 1 here.
  logic [32:0] sum_v;
  always_comb begin
    sum_v        = 33'd0;
    alu_Result   = 32'd0;
    alu_Overflow = 1'b1;
    alu_CarryOut = 1'b1;
    case (alu_ALUop)
      3'b000: alu_Result = alu_A & alu_B;
      3'b001: alu_Result = alu_A | alu_B;
      3'b010: begin
        sum_v        = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Result   = sum_v[31:0];
        alu_CarryOut = sum_v[32];
        alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_Result[31] != alu_A[31]);
      end
      3'b110: begin
        sum_v        = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
        alu_Result   = sum_v[31:0];
        alu_CarryOut = sum_v[32];
        alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_Result[31] != alu_A[31]);
      end
      3'b111: alu_Result = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
      default: alu_Result = 32'd0;
    endcase
    alu_Zero = (alu_Result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Reference: apply the operation N times with 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] it, output logic [31:0] res, output logic ovf,
                       output logic carry, output logic zero, output logic err);
    logic [31:0]     acc;
    longint          sa, sb, s;
    longint unsigned ua, ub;
    acc = a; ovf = 1'b0; carry = 1'b0; zero = 1'b0; err = 1'b0;
    if (!(op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111})) begin
      res = 32'd0; err = 1'b1;
      return;
    end
    for (int i = 0; i <= int'(it); i++) begin
      exp_trace[i] = acc;
      sa = longint'($signed(acc));
      sb = longint'($signed(b));
      ua = {32'd0, acc};
      ub = {32'd0, b};
      case (op)
        3'b010: begin
          s = sa + sb;
          if (s > SMAX || s < SMIN) ovf = 1'b1;
          carry = (ua + ub) > 64'hFFFF_FFFF;
          acc = 32'(ua + ub);
        end
        3'b110: begin
          s = sa - sb;
          if (s > SMAX || s < SMIN) ovf = 1'b1;
          carry = (ua >= ub);
          acc = 32'(ua - ub);
        end
        3'b000: begin acc = acc & b; carry = 1'b0; end
        3'b001: begin acc = acc | b; carry = 1'b0; end
        default: begin acc = (sa < sb) ? 32'd1 : 32'd0; carry = 1'b0; end
      endcase
      zero = (acc == 32'd0);
    end
    res = acc;
  endtask

  // One command: issue, watch execution, backpressure, handshake.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] it, input int hold,
                         input bit early, input bit noise);
    logic [31:0] e_res;
    logic        e_ovf, e_carry, e_zero, e_err;
    int          c;
    int          exp_lat;
    logic [31:0] held;
    model(op, a, b, it, e_res, e_ovf, e_carry, e_zero, e_err);
    exp_lat = e_err ? 1 : int'(it) + 1;
    @(negedge clk);
    check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    rsp_ready = early;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_iter = it;
    @(posedge clk);
    c = 0;
    forever begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid || c > 40) break;
      if (e_err) begin
        check({tag, ".alu_op_idle"}, 32'(alu_ALUop), 32'd0);
      end else if (c < 16) begin
        check($sformatf("%s.alu_A[%0d]", tag, c), alu_A, exp_trace[c]);
      end
      if (noise) begin
        cmd_valid = 1'b1; cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        cmd_iter = 4'($urandom);
      end
      c++;
    end
    check({tag, ".latency"}, 32'(c), 32'(exp_lat));
    check({tag, ".result"}, rsp_result, e_res);
    check({tag, ".overflow"}, 32'(rsp_overflow), 32'(e_ovf));
    check({tag, ".carry"}, 32'(rsp_carry), 32'(e_carry));
    check({tag, ".zero"}, 32'(rsp_zero), 32'(e_zero));
    check({tag, ".err"}, 32'(rsp_err), 32'(e_err));
    if (!early) begin
      held = rsp_result;
      for (int d = 0; d < hold; d++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".hold_result"}, rsp_result, held);
        check({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_cmd_ready"}, 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] op_tbl [0:9];
    logic [31:0] ra, rb;
    bit          seen;
    op_tbl = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b010, 3'b110, 3'b011, 3'b100, 3'b101};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 32'd0; cmd_b = 32'd0;
    cmd_iter = 4'd0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_result", rsp_result, 32'd0);
    check("reset.alu_A", alu_A, 32'd0);
    check("reset.alu_op", 32'(alu_ALUop), 32'd0);
    rst = 1'b0;
    #1;
    check("reset.cmd_ready_release", 32'(cmd_ready), 32'd1);

    run_cmd("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 4'd0, 0, 1'b0, 1'b0);
    run_cmd("add_iter", 3'b010, 32'd0, 32'd3, 4'd4, 0, 1'b0, 1'b0);
    run_cmd("sub_zero", 3'b110, 32'd5, 32'd5, 4'd0, 0, 1'b0, 1'b0);
    run_cmd("slt", 3'b111, 32'hFFFF_FFFF, 32'd1, 4'd0, 0, 1'b0, 1'b0);
    run_cmd("or_zero", 3'b001, 32'd0, 32'd0, 4'd0, 0, 1'b0, 1'b0);
    run_cmd("illegal", 3'b011, 32'h1234_5678, 32'h9, 4'd5, 0, 1'b0, 1'b0);
    run_cmd("backpressure", 3'b010, 32'hFFFF_FFF0, 32'h7, 4'd3, 5, 1'b0, 1'b1);
    run_cmd("early_ready", 3'b110, 32'd1, 32'd2, 4'd15, 0, 1'b1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_cmd($sformatf("rnd%0d", n), op_tbl[$urandom_range(0, 9)], ra, rb,
              4'($urandom_range(0, 15)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of an iterated command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 32'd1; cmd_b = 32'd2; cmd_iter = 4'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_mid.in_exec", 32'(alu_ALUop), 32'b010);
    rst = 1'b1;
    #1;
    check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_mid.alu_op", 32'(alu_ALUop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.cmd_ready_release", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst_mid.no_response", 32'(seen), 32'd0);
    rsp_ready = 1'b0;
    run_cmd("after_rst", 3'b000, 32'hF0F0_FFFF, 32'h0FF0_00FF, 4'd2, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
